// File: rtl/bus_pkg.sv
// Shared definitions for the data-bus fabric: FSM encoding, default
// region map and the error-counter width.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } bus_state_t;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] IO_BASE   = 32'hC000_0000;
  localparam logic [31:0] QUAD_MASK = 32'hC000_0000;

  localparam int ERR_CNT_W = 8;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational base/mask region decoder; the lowest-numbered matching
// region wins when regions overlap.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int                     NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {IO_BASE, RAM_BASE},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {QUAD_MASK, QUAD_MASK}
) (
  input  logic [31:0]                       i_addr,
  output logic                              o_hit,
  output logic [idxWidth(NUM_SLAVES)-1:0]   o_idx,
  output logic [NUM_SLAVES-1:0]             o_onehot
);

  localparam int IDX_W = idxWidth(NUM_SLAVES);

  // Scan from the top down so the lowest matching index is the last to land.
  always_comb begin
    o_hit    = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
    if (o_hit) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/bus_fabric.sv
// CPU data-bus interconnect: decodes a request to one target, waits on its
// ready, and returns data or an error (unmapped address / timeout).
module bus_fabric
  import bus_pkg::*;
#(
  parameter int                       NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {IO_BASE, RAM_BASE},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {QUAD_MASK, QUAD_MASK},
  parameter int                       TIMEOUT    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_req,
  input  logic                       m_we,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  output logic                       m_ready,
  output logic                       m_done,
  output logic                       m_err,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_sel,
  output logic                       s_we,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  output logic [ERR_CNT_W-1:0]       err_count
);

  localparam int IDX_W = idxWidth(NUM_SLAVES);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  bus_state_t r_state, w_next;

  logic                  r_we, r_err;
  logic [31:0]           r_addr, r_wdata, r_rdata;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_SLAVES-1:0] r_sel;
  logic [CNT_W-1:0]      r_cnt;
  logic [ERR_CNT_W-1:0]  r_errCount;

  logic                  w_hit, w_accept, w_slvReady, w_timeout;
  logic [IDX_W-1:0]      w_idx;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic [31:0]           w_slvRdata;

  bus_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .i_addr   (m_addr),
    .o_hit    (w_hit),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  assign w_slvReady = s_ready[r_idx];
  assign w_slvRdata = s_rdata[r_idx*32 +: 32];
  // Ready on the final counted cycle takes priority over the timeout.
  assign w_timeout  = (TIMEOUT != 0) && (int'(r_cnt) + 1 == TIMEOUT);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    m_ready  = 1'b0;
    m_done   = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        m_ready = 1'b1;
        if (m_req) begin
          w_accept = 1'b1;
          w_next   = w_hit ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: if (w_slvReady || w_timeout) w_next = ST_RESP;
      ST_RESP: begin
        m_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_idx      <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_errCount <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= m_we;
        r_addr  <= m_addr;
        r_wdata <= m_wdata;
        r_idx   <= w_idx;
        r_sel   <= w_onehot;
        r_cnt   <= '0;
        r_err   <= !w_hit;
        if (!w_hit) r_rdata <= '0;
      end
      if (r_state == ST_ACCESS) begin
        if (w_slvReady) begin
          r_err   <= 1'b0;
          r_rdata <= r_we ? 32'h0 : w_slvRdata;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
      end
      if (m_done && r_err && (r_errCount != '1)) r_errCount <= r_errCount + 1'b1;
    end
  end

  assign s_sel     = (r_state == ST_ACCESS) ? r_sel : '0;
  assign s_we      = r_we & (|s_sel);
  assign s_addr    = r_addr;
  assign s_wdata   = r_wdata;
  assign m_err     = m_done & r_err;
  assign m_rdata   = r_rdata;
  assign err_count = r_errCount;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: a vector table of single transactions plus
// hand sequences for saturation, data hold, mid-access reset and overlap.
module tb_bus_fabric;

  logic        clk = 1'b0;
  logic        rst;
  logic        mReq, mWe;
  logic [31:0] mAddr, mWdata;
  logic        mReady, mDone, mErr;
  logic [31:0] mRdata;
  logic [1:0]  sSel;
  logic        sWe;
  logic [31:0] sAddr, sWdata;
  logic [1:0]  sReady;
  logic [63:0] sRdata;
  logic [7:0]  errCount;

  logic        oReq;
  logic        oReady, oDone, oErr, oWe;
  logic [31:0] oRdata, oAddr, oWdata;
  logic [1:0]  oSel;
  logic [1:0]  oSReady;
  logic [63:0] oSRdata;
  logic [7:0]  oErrCount;

  int checks = 0;
  int errors = 0;
  int errModel = 0;

  always #5 clk = ~clk;

  bus_fabric #(.NUM_SLAVES(2), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .m_req(mReq), .m_we(mWe), .m_addr(mAddr), .m_wdata(mWdata),
    .m_ready(mReady), .m_done(mDone), .m_err(mErr), .m_rdata(mRdata),
    .s_sel(sSel), .s_we(sWe), .s_addr(sAddr), .s_wdata(sWdata),
    .s_ready(sReady), .s_rdata(sRdata), .err_count(errCount)
  );

  bus_fabric #(.NUM_SLAVES(2), .SLAVE_BASE(64'h0), .SLAVE_MASK(64'h0), .TIMEOUT(4)) u_ovl (
    .clk(clk), .rst(rst), .m_req(oReq), .m_we(mWe), .m_addr(mAddr), .m_wdata(mWdata),
    .m_ready(oReady), .m_done(oDone), .m_err(oErr), .m_rdata(oRdata),
    .s_sel(oSel), .s_we(oWe), .s_addr(oAddr), .s_wdata(oWdata),
    .s_ready(oSReady), .s_rdata(oSRdata), .err_count(oErrCount)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          tgt;
    int          delay;
    logic [31:0] rdata;
    logic        noise;
    int          expLat;
    logic        expErr;
    logic [31:0] expRdata;
    logic [1:0]  expSel;
    int          expSelCyc;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int lat, output logic err,
                               output logic [31:0] rd, output logic [1:0] sel,
                               output int selCyc, output int sideBad);
    lat = -1; err = 1'b0; rd = '0; sel = '0; selCyc = 0; sideBad = 0;
    @(negedge clk);
    sRdata = {32'h2222_2222, 32'h1111_1111};
    if (v.tgt >= 0) sRdata[v.tgt*32 +: 32] = v.rdata;
    sReady = v.noise ? ((v.tgt == 1) ? 2'b01 : 2'b10) : 2'b00;
    mReq = 1'b1; mWe = v.we; mAddr = v.addr; mWdata = v.wdata;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      mReq = 1'b0;
      if (sSel != 2'b00) begin
        if (selCyc == 0) sel = sSel;
        selCyc++;
        if (sWe !== v.we || sAddr !== v.addr || sWdata !== v.wdata) sideBad++;
        if (v.tgt >= 0) sReady[v.tgt] = (v.delay >= 0) && (selCyc == v.delay + 1);
      end
      if (mDone) begin
        lat = c; err = mErr; rd = mRdata;
        break;
      end
    end
    sReady = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, selCyc, sideBad, bad, seen;
    logic err;
    logic [31:0] rd;
    logic [1:0] sel;

    vecs[0] = '{32'h0000_0010, 1'b0, 32'h0,         0,  0, 32'h1234_5678, 1'b0, 2, 1'b0, 32'h1234_5678, 2'b01, 1};
    vecs[1] = '{32'hC000_0004, 1'b1, 32'hA5A5_A5A5, 1,  3, 32'h5555_AAAA, 1'b0, 5, 1'b0, 32'h0,         2'b10, 4};
    vecs[2] = '{32'h4000_0000, 1'b0, 32'h0,        -1,  0, 32'h0,         1'b0, 1, 1'b1, 32'h0,         2'b00, 0};
    vecs[3] = '{32'hC000_0100, 1'b0, 32'h0,         1,  1, 32'hDEAD_BEEF, 1'b1, 3, 1'b0, 32'hDEAD_BEEF, 2'b10, 2};
    vecs[4] = '{32'h0000_0020, 1'b0, 32'h0,         0, -1, 32'h7777_7777, 1'b0, 5, 1'b1, 32'h0,         2'b01, 4};
    vecs[5] = '{32'h3FFF_FFFC, 1'b0, 32'h0,         0,  3, 32'hCAFE_F00D, 1'b0, 5, 1'b0, 32'hCAFE_F00D, 2'b01, 4};
    vecs[6] = '{32'h8000_0000, 1'b1, 32'h1357_9BDF,-1,  0, 32'h0,         1'b0, 1, 1'b1, 32'h0,         2'b00, 0};
    vecs[7] = '{32'h0000_0004, 1'b0, 32'h0,         0,  0, 32'h0BAD_C0DE, 1'b1, 2, 1'b0, 32'h0BAD_C0DE, 2'b01, 1};

    rst = 1'b0; mReq = 1'b0; mWe = 1'b0; mAddr = '0; mWdata = '0;
    sReady = '0; sRdata = '0; oReq = 1'b0;
    oSReady = 2'b11; oSRdata = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReady",    32'(mReady),   32'd1);
    checkOutput("rstSel",      32'(sSel),     32'd0);
    checkOutput("rstWe",       32'(sWe),      32'd0);
    checkOutput("rstDone",     32'(mDone),    32'd0);
    checkOutput("rstErr",      32'(mErr),     32'd0);
    checkOutput("rstRdata",    mRdata,        32'd0);
    checkOutput("rstAddr",     sAddr,         32'd0);
    checkOutput("rstWdata",    sWdata,        32'd0);
    checkOutput("rstErrCount", 32'(errCount), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], lat, err, rd, sel, selCyc, sideBad);
      checkOutput($sformatf("v%0d latency", i),  32'(lat),     32'(vecs[i].expLat));
      checkOutput($sformatf("v%0d err", i),      32'(err),     32'(vecs[i].expErr));
      checkOutput($sformatf("v%0d rdata", i),    rd,           vecs[i].expRdata);
      checkOutput($sformatf("v%0d sel", i),      32'(sel),     32'(vecs[i].expSel));
      checkOutput($sformatf("v%0d selCycles", i),32'(selCyc),  32'(vecs[i].expSelCyc));
      checkOutput($sformatf("v%0d sideband", i), 32'(sideBad), 32'd0);
      if (vecs[i].expErr && errModel < 255) errModel++;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("v%0d donePulse", i), 32'(mDone),    32'd0);
      checkOutput($sformatf("v%0d readyBack", i), 32'(mReady),   32'd1);
      checkOutput($sformatf("v%0d errCount", i),  32'(errCount), 32'(errModel));
    end

    repeat (5) @(negedge clk);
    checkOutput("rdataHold", mRdata, 32'h0BAD_C0DE);

    bad = 0;
    for (int n = 0; n < 300; n++) begin
      applyStimulus(vecs[4], lat, err, rd, sel, selCyc, sideBad);
      if (lat != 5 || err !== 1'b1) bad++;
      if (errModel < 255) errModel++;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("satTimeouts", 32'(bad),      32'd0);
    checkOutput("satErrCount", 32'(errCount), 32'd255);

    @(negedge clk);
    mReq = 1'b1; mWe = 1'b0; mAddr = 32'h0000_0010; sReady = 2'b00;
    @(posedge clk);
    @(negedge clk);
    mReq = 1'b0;
    checkOutput("midRstPreSel", 32'(sSel), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRstSel",      32'(sSel),     32'd0);
    checkOutput("midRstReady",    32'(mReady),   32'd1);
    checkOutput("midRstDone",     32'(mDone),    32'd0);
    checkOutput("midRstErrCount", 32'(errCount), 32'd0);
    rst = 1'b1;
    errModel = 0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (mDone) seen++;
    end
    checkOutput("midRstNoDone", 32'(seen), 32'd0);
    applyStimulus(vecs[0], lat, err, rd, sel, selCyc, sideBad);
    checkOutput("postRstLatency", 32'(lat), 32'd2);
    checkOutput("postRstRdata",   rd,       32'h1234_5678);

    @(negedge clk);
    mAddr = 32'hC000_0008; mWe = 1'b0; oReq = 1'b1;
    lat = -1;
    rd = '0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      oReq = 1'b0;
      if (c == 1) checkOutput("ovlSel", 32'(oSel), 32'd1);
      if (oDone) begin
        lat = c;
        rd = oRdata;
        break;
      end
    end
    checkOutput("ovlLatency", 32'(lat), 32'd2);
    checkOutput("ovlRdata",   rd,       32'hAAAA_AAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
